// File: rtl/dbg_pkg.sv
// Shared definitions for the debug scan arbiter: FSM encoding, line levels, gap limits.
// The PAR state exists only when DBG_PARITY_EN is defined.
package dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ID,
    S_DATA,
`ifdef DBG_PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_GAP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int unsigned GAP_MIN = 0;
  localparam int unsigned GAP_MAX = 15;

endpackage

// File: rtl/dbg_rr_arb.sv
// Combinational 4-way round-robin picker; search starts at last+1 and wraps,
// so the previous winner has the lowest priority.
module dbg_rr_arb
  import dbg_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] grant
);

  logic [1:0] idx;

  always_comb begin
    valid = |req;
    grant = last;
    idx   = '0;
    // Walk from furthest to nearest so the nearest requester overwrites last.
    for (int unsigned i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/debug_scan_arb.sv
// Debug scan arbiter: grants one of four status groups round-robin and shifts
// start, group id, status word, optional parity (DBG_PARITY_EN) and stop out serially.
module debug_scan_arb
  import dbg_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic            debug_clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] data,
  output logic [3:0]      ack,
  output logic            debug_out,
  output logic            frame_active,
  output logic [1:0]      grp_id
);

  localparam int unsigned CW      = $clog2(DW) + 1;
  localparam int unsigned GAP_EFF = (GAP_CYC > GAP_MAX) ? GAP_MAX : GAP_CYC;

  state_t          state;
  logic [1:0]      last_grant;
  logic [DW-1:0]   shreg;
  logic [CW-1:0]   bit_cnt;
  logic [3:0]      gap_cnt;
  logic            arb_valid;
  logic [1:0]      arb_grant;
  logic            frame_done;
  logic [DW-1:0]   grant_word;
`ifdef DBG_PARITY_EN
  logic            parity;
`endif

  dbg_rr_arb u_arb (
    .req   (req),
    .last  (last_grant),
    .valid (arb_valid),
    .grant (arb_grant)
  );

  assign grant_word = data[arb_grant*DW +: DW];

  // A new grant may be taken in IDLE or on the edge that would otherwise
  // return to IDLE, so consecutive frames are separated by the gap alone.
  always_comb begin
    frame_done = 1'b0;
    case (state)
      S_IDLE:  frame_done = 1'b1;
      S_STOP:  frame_done = (GAP_EFF == 0);
      S_GAP:   frame_done = (gap_cnt == '0);
      default: frame_done = 1'b0;
    endcase
  end

  always_ff @(posedge debug_clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      last_grant   <= 2'd3;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      ack          <= '0;
      debug_out    <= STOP_BIT;
      frame_active <= 1'b0;
      grp_id       <= '0;
`ifdef DBG_PARITY_EN
      parity       <= 1'b0;
`endif
    end else begin
      ack <= '0;
      if (frame_done && enable && arb_valid) begin
        state          <= S_START;
        ack[arb_grant] <= 1'b1;
        debug_out      <= START_BIT;
        frame_active   <= 1'b1;
        grp_id         <= arb_grant;
        last_grant     <= arb_grant;
        shreg          <= grant_word;
`ifdef DBG_PARITY_EN
        parity         <= ^{arb_grant, grant_word};
`endif
      end else begin
        case (state)
          S_START: begin
            state     <= S_ID;
            debug_out <= grp_id[1];
            bit_cnt   <= CW'(1);
          end
          S_ID: begin
            if (bit_cnt == '0) begin
              state     <= S_DATA;
              debug_out <= shreg[DW-1];
              shreg     <= shreg << 1;
              bit_cnt   <= CW'(DW - 1);
            end else begin
              debug_out <= grp_id[0];
              bit_cnt   <= bit_cnt - 1'b1;
            end
          end
          S_DATA: begin
            if (bit_cnt == '0) begin
`ifdef DBG_PARITY_EN
              state     <= S_PAR;
              debug_out <= parity;
`else
              state     <= S_STOP;
              debug_out <= STOP_BIT;
`endif
            end else begin
              debug_out <= shreg[DW-1];
              shreg     <= shreg << 1;
              bit_cnt   <= bit_cnt - 1'b1;
            end
          end
`ifdef DBG_PARITY_EN
          S_PAR: begin
            state     <= S_STOP;
            debug_out <= STOP_BIT;
          end
`endif
          S_STOP: begin
            frame_active <= 1'b0;
            debug_out    <= STOP_BIT;
            if (GAP_EFF == 0) begin
              state <= S_IDLE;
            end else begin
              state   <= S_GAP;
              gap_cnt <= 4'(GAP_EFF - 1);
            end
          end
          S_GAP: begin
            debug_out <= STOP_BIT;
            if (gap_cnt == '0) state <= S_IDLE;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          default: begin
            state     <= S_IDLE;
            debug_out <= STOP_BIT;
          end
        endcase
      end
    end
  end

endmodule
